// File: rtl/wb_b3_mem_tester.sv
// Wishbone B3 memory tester: writes an LFSR pattern to a window, reads back and checks.
// Ports: clk/rst_n, start/busy/done/pass/err_count/first_err_adr, Wishbone master; WB_MEM_TESTER_BURST_EN enables bursts.
module wb_b3_mem_tester #(
  parameter int              AW        = 27,
  parameter logic [AW-1:0]   BASE      = '0,
  parameter int              WORDS     = 256,
  parameter int              BURST_LEN = 4,
  parameter logic [31:0]     SEED      = 32'h0000_0001
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_adr,
  output logic [AW-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

`ifdef WB_MEM_TESTER_BURST_EN
  localparam int BL    = BURST_LEN;
  localparam bit BURST = 1'b1;
`else
  // classic cycles: every beat is a burst of one
  localparam int BL    = 1 + 0 * BURST_LEN;
  localparam bit BURST = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_WGAP = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_RGAP = 3'd4;

  logic [2:0]  state;
  logic [31:0] lfsr;
  logic [31:0] idx;
  logic [3:0]  beat;
  logic        err_seen;

  logic        term;
  logic        retry;
  logic        beat_err;
  logic        rd_bad;
  logic        is_err;
  logic        last_word;
  logic        last_beat;
  logic [3:0]  beat_nx;
  logic [15:0] err_next;
  logic [31:0] lfsr_nx;

  function automatic logic [2:0] cti_for(input logic last);
    if (!BURST) return 3'b000;
    return last ? 3'b111 : 3'b010;
  endfunction

  assign wb_bte_o = 2'b00;

  assign term     = wb_cyc_o & wb_stb_o
                  & (wb_ack_i | wb_err_i);
  assign retry    = wb_cyc_o & wb_stb_o & wb_rty_i
                  & ~wb_ack_i & ~wb_err_i;
  assign beat_err = ~wb_ack_i & wb_err_i;
  // ack wins over err, so only an acked read is compared
  assign rd_bad   = ~wb_we_o & wb_ack_i
                  & (wb_dat_i != lfsr);
  assign is_err   = term & (beat_err | rd_bad);

  assign last_word = (idx == 32'(WORDS - 1));
  assign last_beat = (beat == 4'(BL - 1));
  assign beat_nx   = last_beat ? 4'd0 : beat + 4'd1;

  assign err_next = (is_err && err_count != 16'hFFFF)
                  ? err_count + 16'd1 : err_count;

  assign lfsr_nx = {lfsr[30:0],
                    lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lfsr          <= SEED;
      idx           <= '0;
      beat          <= '0;
      err_seen      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_adr <= '0;
      wb_adr_o      <= BASE;
      wb_dat_o      <= '0;
      wb_sel_o      <= '0;
      wb_we_o       <= 1'b0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_cti_o      <= 3'b000;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_WR;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_adr <= '0;
            err_seen      <= 1'b0;
            lfsr          <= SEED;
            idx           <= '0;
            beat          <= '0;
            wb_cyc_o      <= 1'b1;
            wb_stb_o      <= 1'b1;
            wb_we_o       <= 1'b1;
            wb_sel_o      <= 4'hF;
            wb_adr_o      <= BASE;
            wb_dat_o      <= SEED;
            wb_cti_o      <= cti_for(BL == 1);
          end
        end
        S_WR, S_RD: begin
          if (!wb_stb_o) begin
            // reissue the beat that was retried
            wb_stb_o <= 1'b1;
          end else if (term) begin
            err_count <= err_next;
            if (is_err && !err_seen) begin
              err_seen      <= 1'b1;
              first_err_adr <= wb_adr_o;
            end
            lfsr     <= lfsr_nx;
            idx      <= idx + 32'd1;
            beat     <= beat_nx;
            wb_adr_o <= wb_adr_o + AW'(4);
            if (state == S_WR)
              wb_dat_o <= lfsr_nx;
            wb_cti_o <= cti_for(beat_nx == 4'(BL - 1));
            if (last_word) begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              wb_we_o  <= 1'b0;
              if (state == S_WR) begin
                state    <= S_RGAP;
                lfsr     <= SEED;
                idx      <= '0;
                beat     <= '0;
                wb_adr_o <= BASE;
                wb_cti_o <= cti_for(BL == 1);
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_next == 16'd0);
              end
            end else if (last_beat) begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              state    <= (state == S_WR) ? S_WGAP : S_RGAP;
            end
          end else if (retry) begin
            wb_stb_o <= 1'b0;
          end
        end
        S_WGAP: begin
          state    <= S_WR;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
        end
        S_RGAP: begin
          state    <= S_RD;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_b3_mem_tester.md
# wb_b3_mem_tester

Wishbone B3 bus master that writes a pseudo-random pattern into a word-aligned memory window, then reads it back and compares. It is the initiator counterpart of the simulation `wb_ram` responder and sits on the external memory bus in place of, or muxed with, the SoC core's `wb_ext` master. It gives benches and bring-up a self-checking memory stimulus that exercises B3 incrementing bursts.

## Interface
Parameters:
- `AW`, 27: byte-address width (matches a 128 MB `MEM_SIZE`).
- `BASE`, 0: byte base address of the window; must be 4-byte aligned.
- `WORDS`, 256: number of 32-bit words tested; a multiple of `BURST_LEN`, at least 1.
- `BURST_LEN`, 4: beats per burst, 1..16.
- `SEED`, 32'h0000_0001: LFSR seed; must be nonzero.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; starts a run when idle.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until next `start`.
- `pass`  out  1  `done` with `err_count` == 0.
- `err_count`  out  16  mismatches plus `err_i` beats, saturating at 16'hFFFF.
- `first_err_adr`  out  AW  byte address of the first failing beat.
- `wb_adr_o`  out  AW  byte address.
- `wb_dat_o`  out  32  write data.
- `wb_sel_o`  out  4  byte selects, always 4'hF while `stb` is high.
- `wb_we_o`  out  1  write enable.
- `wb_cyc_o`, `wb_stb_o`  out  1  cycle and strobe.
- `wb_cti_o`  out  3  cycle type.
- `wb_bte_o`  out  2  burst type, always 2'b00 (linear).
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`, `wb_err_i`, `wb_rty_i`  in  1  slave terminations.

## Operation
- The state machine has five states: IDLE, WR, WGAP, RD, RGAP.
- IDLE -> WR on `start`. At that transition `err_count` and `done` are cleared, the LFSR is loaded with `SEED` and the word index is set to 0. `start` in any other state is ignored.
- Pattern: a 32-bit Fibonacci LFSR, next = {l[30:0], l[31]^l[21]^l[1]^l[0]}. It advances once per acked beat. With seed 1 the sequence is 0x1, 0x3, 0x6, 0xD, …
- Word i is at byte address `BASE` + 4·i and wraps modulo 2^AW.
- WR: writes beat by beat (`we` = 1, `dat_o` = LFSR).
  - After the last beat of a burst: go to WGAP, or to RD/RGAP handling if all `WORDS` are written.
  - WGAP: one cycle with `cyc` low, then back to WR.
- After the final write: go to RGAP, reload the LFSR with `SEED`, reset the index to 0, then enter RD.
- RD: same burst structure with `we` = 0.
  - On each ack, `dat_i` is compared with the LFSR value.
  - A mismatch increments `err_count` and captures `first_err_adr` if this is the first error.
  - After the final read: go to IDLE, set `done`, clear `busy`.
- `err_i`: the beat counts as an error (it increments `err_count` and may capture `first_err_adr`). The address and LFSR still advance.
- `rty_i`: no advance. `stb` is dropped for one cycle and the same beat is reissued with the same cti.
- If ack, err and rty are asserted together, ack takes priority, then err.
- `err_count` saturates; `first_err_adr` is written only once per run.

## Timing
- Reset values: `busy`, `done`, `pass`, `cyc`, `stb` and `we` = 0; `err_count` = 0; `first_err_adr` = 0; `adr` = `BASE`; `dat_o` = 0; `cti` = 3'b000; `sel` = 0. Reset is effective mid-burst: the bus is released immediately.
- All outputs are registered.
- `cyc` and `stb` rise in the cycle after the IDLE -> WR or GAP -> access transition.
- On an acked beat, the next address, data and cti appear in the following cycle with `stb` kept high. Throughput is one beat per cycle when the slave holds ack.
- `stb` is held with stable address, data and cti until terminated.
- `busy` rises the cycle after `start`. `done` and `pass` rise the cycle after the final read ack, and `err_count` is final in that same cycle.

## Configuration
- `WB_MEM_TESTER_BURST_EN` defined:
  - `cti` = 3'b010 on every burst beat except the last, which uses 3'b111.
  - A gap occurs only after each `BURST_LEN` beats.
- Not defined:
  - Classic cycles only: `cti` = 3'b000, `BURST_LEN` is treated as 1, and there is a one-cycle `cyc`-low gap after every beat.
  - `WORDS` only needs to be ≥1.

## Test plan
- Burst mode, `wb_ram` slave, `WORDS` = 8, `SEED` = 1, `start` pulse:
  - writes at 0x0, 0x4, …, 0x1C with data 0x1, 0x3, 0x6, 0xD, …
  - cti sequence 010,010,010,111 twice;
  - `done` = `pass` = 1, `err_count` = 0.
- Slave that corrupts bit 0 of the read at 0x8: `err_count` = 1, `first_err_adr` = 0x8, `pass` = 0.
- Slave asserts `rty_i` on the first write beat: one `stb`-low cycle, then the same address 0x0 and data 0x1 are reissued; the run still passes.
- Slave asserts `err_i` on reads at 0x4 and 0xC: `err_count` = 2, `first_err_adr` = 0x4.
- `rst_n` is asserted low mid-burst during RD:
  - `cyc`, `stb`, `busy` = 0 asynchronously;
  - after release, a new `start` completes with `pass` = 1.
- Macro undefined, `WORDS` = 3: three writes and three reads, all with `cti` = 000 and a `cyc`-low cycle between beats; `start` pulsed while busy has no effect.
